// File: rtl/id_ex_stage_reg_pkg.sv
// Shared ARM core definitions: EXE commands, shifter types, flag indices.
// Also holds the ID->EXE control bundle and the bubble-gating helper.
package arm_pkg;

    localparam int EXE_CMD_W  = 4;
    localparam int SHIFT_OP_W = 12;
    localparam int SIMM_W     = 24;
    localparam int NZCV_W     = 4;

    localparam logic [EXE_CMD_W-1:0] EXE_MOV = 4'b0001;
    localparam logic [EXE_CMD_W-1:0] EXE_MVN = 4'b1001;
    localparam logic [EXE_CMD_W-1:0] EXE_ADD = 4'b0010;
    localparam logic [EXE_CMD_W-1:0] EXE_ADC = 4'b0011;
    localparam logic [EXE_CMD_W-1:0] EXE_SUB = 4'b0100;
    localparam logic [EXE_CMD_W-1:0] EXE_SBC = 4'b0101;
    localparam logic [EXE_CMD_W-1:0] EXE_AND = 4'b0110;
    localparam logic [EXE_CMD_W-1:0] EXE_ORR = 4'b0111;
    localparam logic [EXE_CMD_W-1:0] EXE_EOR = 4'b1000;

    localparam logic [1:0] SH_LSL = 2'b00;
    localparam logic [1:0] SH_LSR = 2'b01;
    localparam logic [1:0] SH_ASR = 2'b10;
    localparam logic [1:0] SH_ROR = 2'b11;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef struct packed {
        logic                 wb_en;
        logic                 mem_r_en;
        logic                 mem_w_en;
        logic                 b;
        logic                 s;
        logic [EXE_CMD_W-1:0] exe_cmd;
    } ctrl_t;

    // A bubble keeps its command code but loses every side-effect bit.
    function automatic ctrl_t gate_ctrl(ctrl_t c, logic v);
        ctrl_t r;
        r          = c;
        r.wb_en    = c.wb_en & v;
        r.mem_r_en = c.mem_r_en & v;
        r.mem_w_en = c.mem_w_en & v;
        r.b        = c.b & v;
        r.s        = c.s & v;
        return r;
    endfunction

endpackage

// File: rtl/id_ex_stage_reg_if.sv
// ID->EXE bundle: ID-side fields (_in) and registered EXE-side copies (_out).
interface id_ex_stage_reg_if #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 4,
    parameter int CMD_W      = 4
);
    logic                  in_valid;
    logic [DATA_W-1:0]     pc_in;
    logic [CMD_W-1:0]      exe_cmd_in;
    logic                  wb_en_in;
    logic                  mem_r_en_in;
    logic                  mem_w_en_in;
    logic                  b_in;
    logic                  s_in;
    logic [DATA_W-1:0]     val_rn_in;
    logic [DATA_W-1:0]     val_rm_in;
    logic                  imm_in;
    logic [11:0]           shift_operand_in;
    logic [23:0]           signed_imm_24_in;
    logic [REG_ADDR_W-1:0] dest_in;
    logic [3:0]            status_in;

    logic                  valid_out;
    logic [DATA_W-1:0]     pc_out;
    logic [CMD_W-1:0]      exe_cmd_out;
    logic                  wb_en_out;
    logic                  mem_r_en_out;
    logic                  mem_w_en_out;
    logic                  b_out;
    logic                  s_out;
    logic [DATA_W-1:0]     val_rn_out;
    logic [DATA_W-1:0]     val_rm_out;
    logic                  imm_out;
    logic [11:0]           shift_operand_out;
    logic [23:0]           signed_imm_24_out;
    logic [REG_ADDR_W-1:0] dest_out;
    logic [3:0]            status_out;
    logic                  is_mem_out;

    modport master (
        output in_valid, pc_in, exe_cmd_in, wb_en_in, mem_r_en_in,
        output mem_w_en_in, b_in, s_in, val_rn_in, val_rm_in, imm_in,
        output shift_operand_in, signed_imm_24_in, dest_in, status_in,
        input  valid_out, pc_out, exe_cmd_out, wb_en_out, mem_r_en_out,
        input  mem_w_en_out, b_out, s_out, val_rn_out, val_rm_out, imm_out,
        input  shift_operand_out, signed_imm_24_out, dest_out, status_out,
        input  is_mem_out
    );

    modport slave (
        input  in_valid, pc_in, exe_cmd_in, wb_en_in, mem_r_en_in,
        input  mem_w_en_in, b_in, s_in, val_rn_in, val_rm_in, imm_in,
        input  shift_operand_in, signed_imm_24_in, dest_in, status_in,
        output valid_out, pc_out, exe_cmd_out, wb_en_out, mem_r_en_out,
        output mem_w_en_out, b_out, s_out, val_rn_out, val_rm_out, imm_out,
        output shift_operand_out, signed_imm_24_out, dest_out, status_out,
        output is_mem_out
    );

endinterface

// File: rtl/pipe_reg_en_clr.sv
// Pipeline register: async active-low reset, sync clear beats enable.
module pipe_reg_en_clr #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         clr,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/sat_counter16.sv
// 16-bit saturating event counter; only built with ID_EX_PERF_EN.
`ifdef ID_EX_PERF_EN
module sat_counter16 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        inc,
    output logic [15:0] cnt
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (inc && cnt != 16'hFFFF) begin
            cnt <= cnt + 16'd1;
        end
    end

endmodule
`endif

// File: rtl/id_ex_stage_reg.sv
// ID->EXE pipeline register with freeze, flush and bubble gating.
// Define ID_EX_PERF_EN to add saturating flush/stall counters.
module id_ex_stage_reg
    import arm_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 4,
    parameter int CMD_W      = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               freeze,
    input  logic               flush,
    id_ex_stage_reg_if.slave   bus
`ifdef ID_EX_PERF_EN
    ,
    output logic [15:0]        flush_cnt_out,
    output logic [15:0]        stall_cnt_out
`endif
);

    localparam int CTRL_W = $bits(ctrl_t) + 2;
    localparam int DATA_BUS_W = 3 * DATA_W + 1 + SHIFT_OP_W
                              + SIMM_W + REG_ADDR_W + NZCV_W;

    ctrl_t                 ctrl_raw;
    ctrl_t                 ctrl_d;
    ctrl_t                 ctrl_q;
    logic                  valid_q;
    logic                  is_mem_q;
    logic                  load_en;
    logic [CTRL_W-1:0]     ctrl_reg_d;
    logic [CTRL_W-1:0]     ctrl_reg_q;
    logic [DATA_BUS_W-1:0] data_reg_d;
    logic [DATA_BUS_W-1:0] data_reg_q;

    always_comb begin
        ctrl_raw          = '0;
        ctrl_raw.wb_en    = bus.wb_en_in;
        ctrl_raw.mem_r_en = bus.mem_r_en_in;
        ctrl_raw.mem_w_en = bus.mem_w_en_in;
        ctrl_raw.b        = bus.b_in;
        ctrl_raw.s        = bus.s_in;
        ctrl_raw.exe_cmd  = bus.exe_cmd_in;
    end

    assign load_en = ~freeze;
    assign ctrl_d  = gate_ctrl(ctrl_raw, bus.in_valid);

    // is_mem derives from gated bits so a bubble never looks like a memory op.
    assign ctrl_reg_d = {bus.in_valid,
                         ctrl_d.mem_r_en | ctrl_d.mem_w_en,
                         ctrl_d};
    assign {valid_q, is_mem_q, ctrl_q} = ctrl_reg_q;

    assign data_reg_d = {bus.pc_in, bus.val_rn_in, bus.val_rm_in,
                         bus.imm_in, bus.shift_operand_in,
                         bus.signed_imm_24_in, bus.dest_in,
                         bus.status_in};

    pipe_reg_en_clr #(.W(CTRL_W)) u_ctrl_reg (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (load_en),
        .clr   (flush),
        .d     (ctrl_reg_d),
        .q     (ctrl_reg_q)
    );

    pipe_reg_en_clr #(.W(DATA_BUS_W)) u_data_reg (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (load_en),
        .clr   (flush),
        .d     (data_reg_d),
        .q     (data_reg_q)
    );

    assign bus.valid_out    = valid_q;
    assign bus.is_mem_out   = is_mem_q;
    assign bus.wb_en_out    = ctrl_q.wb_en;
    assign bus.mem_r_en_out = ctrl_q.mem_r_en;
    assign bus.mem_w_en_out = ctrl_q.mem_w_en;
    assign bus.b_out        = ctrl_q.b;
    assign bus.s_out        = ctrl_q.s;
    assign bus.exe_cmd_out  = ctrl_q.exe_cmd;

    assign {bus.pc_out, bus.val_rn_out, bus.val_rm_out,
            bus.imm_out, bus.shift_operand_out,
            bus.signed_imm_24_out, bus.dest_out,
            bus.status_out} = data_reg_q;

`ifdef ID_EX_PERF_EN
    logic stall_evt;

    assign stall_evt = freeze & ~flush;

    sat_counter16 u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (flush),
        .cnt   (flush_cnt_out)
    );

    sat_counter16 u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (stall_evt),
        .cnt   (stall_cnt_out)
    );
`endif

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Scoreboard bench for id_ex_stage_reg: reset, load, freeze, flush, bubble.
// Perf counters are exercised when ID_EX_PERF_EN is defined.
module tb_id_ex_stage_reg;

    typedef logic [151:0] ovec_t;

    logic clk;
    logic rst_n;
    logic freeze;
    logic flush;
`ifdef ID_EX_PERF_EN
    logic [15:0] flush_cnt_out;
    logic [15:0] stall_cnt_out;
`endif

    int    n_err;
    int    n_chk;
    ovec_t mstate;
    ovec_t sb[$];
    ovec_t got;
    ovec_t exp_v;

    id_ex_stage_reg_if #(.DATA_W(32), .REG_ADDR_W(4), .CMD_W(4)) bus ();

    id_ex_stage_reg #(.DATA_W(32), .REG_ADDR_W(4), .CMD_W(4)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .freeze        (freeze),
        .flush         (flush),
        .bus           (bus)
`ifdef ID_EX_PERF_EN
        ,
        .flush_cnt_out (flush_cnt_out),
        .stall_cnt_out (stall_cnt_out)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic ovec_t sample();
        return {bus.valid_out, bus.wb_en_out, bus.mem_r_en_out,
                bus.mem_w_en_out, bus.b_out, bus.s_out, bus.is_mem_out,
                bus.exe_cmd_out, bus.pc_out, bus.val_rn_out,
                bus.val_rm_out, bus.imm_out, bus.shift_operand_out,
                bus.signed_imm_24_out, bus.dest_out, bus.status_out};
    endfunction

    // Reference next state from the current inputs.
    function automatic ovec_t next_exp(ovec_t cur);
        logic v;
        if (flush) return '0;
        if (freeze) return cur;
        v = bus.in_valid;
        return {v, v & bus.wb_en_in, v & bus.mem_r_en_in,
                v & bus.mem_w_en_in, v & bus.b_in, v & bus.s_in,
                v & (bus.mem_r_en_in | bus.mem_w_en_in),
                bus.exe_cmd_in, bus.pc_in, bus.val_rn_in, bus.val_rm_in,
                bus.imm_in, bus.shift_operand_in, bus.signed_imm_24_in,
                bus.dest_in, bus.status_in};
    endfunction

    task automatic edge_step();
        mstate = next_exp(mstate);
        sb.push_back(mstate);
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.in_valid         = 1'b0;
        bus.pc_in            = '0;
        bus.exe_cmd_in       = '0;
        bus.wb_en_in         = 1'b0;
        bus.mem_r_en_in      = 1'b0;
        bus.mem_w_en_in      = 1'b0;
        bus.b_in             = 1'b0;
        bus.s_in             = 1'b0;
        bus.val_rn_in        = '0;
        bus.val_rm_in        = '0;
        bus.imm_in           = 1'b0;
        bus.shift_operand_in = '0;
        bus.signed_imm_24_in = '0;
        bus.dest_in          = '0;
        bus.status_in        = '0;
    endtask

    task automatic rand_inputs();
        bus.in_valid         = 1'($urandom);
        bus.pc_in            = $urandom;
        bus.exe_cmd_in       = 4'($urandom);
        bus.wb_en_in         = 1'($urandom);
        bus.mem_r_en_in      = 1'($urandom);
        bus.mem_w_en_in      = 1'($urandom);
        bus.b_in             = 1'($urandom);
        bus.s_in             = 1'($urandom);
        bus.val_rn_in        = $urandom;
        bus.val_rm_in        = $urandom;
        bus.imm_in           = 1'($urandom);
        bus.shift_operand_in = 12'($urandom);
        bus.signed_imm_24_in = 24'($urandom);
        bus.dest_in          = 4'($urandom);
        bus.status_in        = 4'($urandom);
    endtask

    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        #1;
        mstate = '0;
        sb.delete();
        @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n  = 1'b1;
        freeze = 1'b0;
        flush  = 1'b0;
        rand_inputs();
        bus.in_valid = 1'b1;
        bus.wb_en_in = 1'b1;
        bus.pc_in    = 32'hFFFF_FFF0;
        edge_step();
        got = sample(); exp_v = sb.pop_front(); n_chk++;
        if (got !== exp_v) begin
            n_err++;
            $display("FAIL pre_reset_load: got=%h exp=%h", got, exp_v);
        end
        #2;
        rst_n = 1'b0;
        #1;
        mstate = '0;
        sb.delete();
        got = sample(); n_chk++;
        if (got !== '0) begin
            n_err++;
            $display("FAIL reset_async: got=%h exp=0", got);
        end
`ifdef ID_EX_PERF_EN
        n_chk++;
        if (flush_cnt_out !== 16'd0 || stall_cnt_out !== 16'd0) begin
            n_err++;
            $display("FAIL reset_cnt: got=%h/%h exp=0",
                     flush_cnt_out, stall_cnt_out);
        end
`endif
        @(posedge clk);
        #1;
        got = sample(); n_chk++;
        if (got !== '0) begin
            n_err++;
            $display("FAIL reset_held: got=%h exp=0", got);
        end
        #2;
        rst_n  = 1'b1;
        freeze = 1'b1;
        edge_step();
        got = sample(); exp_v = sb.pop_front(); n_chk++;
        if (got !== exp_v || bus.valid_out !== 1'b0) begin
            n_err++;
            $display("FAIL release_valid: got=%h exp=%h", got, exp_v);
        end
        freeze = 1'b0;
    endtask

    task automatic test_load();
        clear_inputs();
        bus.in_valid         = 1'b1;
        bus.pc_in            = 32'h0000_0010;
        bus.val_rm_in        = 32'hDEAD_BEEF;
        bus.shift_operand_in = 12'h1A3;
        bus.mem_r_en_in      = 1'b1;
        edge_step();
        got = sample(); exp_v = sb.pop_front(); n_chk++;
        if (got !== exp_v) begin
            n_err++;
            $display("FAIL load: got=%h exp=%h", got, exp_v);
        end
        n_chk++;
        if (bus.pc_out !== 32'h10 || bus.val_rm_out !== 32'hDEAD_BEEF ||
            bus.shift_operand_out !== 12'h1A3 || bus.is_mem_out !== 1'b1 ||
            bus.valid_out !== 1'b1) begin
            n_err++;
            $display("FAIL load_fields: pc=%h rm=%h sh=%h mem=%b v=%b",
                     bus.pc_out, bus.val_rm_out, bus.shift_operand_out,
                     bus.is_mem_out, bus.valid_out);
        end
    endtask

    task automatic test_freeze();
        ovec_t held;
        logic [31:0] pc_new;
        held   = sample();
        freeze = 1'b1;
        for (int i = 0; i < 3; i++) begin
            rand_inputs();
            bus.pc_in = 32'h1000 + 32'(i);
            edge_step();
            got = sample(); exp_v = sb.pop_front(); n_chk++;
            if (got !== exp_v || got !== held) begin
                n_err++;
                $display("FAIL freeze_hold%0d: got=%h exp=%h", i, got, exp_v);
            end
        end
        freeze = 1'b0;
        pc_new = bus.pc_in;
        edge_step();
        got = sample(); exp_v = sb.pop_front(); n_chk++;
        if (got !== exp_v || bus.pc_out !== pc_new) begin
            n_err++;
            $display("FAIL freeze_release: got=%h exp=%h", got, exp_v);
        end
    endtask

    task automatic test_flush_freeze();
        rand_inputs();
        flush        = 1'b1;
        freeze       = 1'b1;
        bus.wb_en_in = 1'b1;
        bus.in_valid = 1'b1;
        edge_step();
        got = sample(); exp_v = sb.pop_front(); n_chk++;
        if (got !== exp_v || got !== '0) begin
            n_err++;
            $display("FAIL flush_freeze: got=%h exp=%h", got, exp_v);
        end
        flush  = 1'b0;
        freeze = 1'b0;
    endtask

    task automatic test_bubble();
        rand_inputs();
        bus.in_valid    = 1'b0;
        bus.wb_en_in    = 1'b1;
        bus.mem_w_en_in = 1'b1;
        bus.val_rn_in   = 32'h5;
        edge_step();
        got = sample(); exp_v = sb.pop_front(); n_chk++;
        if (got !== exp_v) begin
            n_err++;
            $display("FAIL bubble: got=%h exp=%h", got, exp_v);
        end
        n_chk++;
        if (bus.wb_en_out !== 1'b0 || bus.mem_w_en_out !== 1'b0 ||
            bus.is_mem_out !== 1'b0 || bus.val_rn_out !== 32'h5) begin
            n_err++;
            $display("FAIL bubble_fields: wb=%b mw=%b mem=%b rn=%h",
                     bus.wb_en_out, bus.mem_w_en_out, bus.is_mem_out,
                     bus.val_rn_out);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            rand_inputs();
            freeze = ($urandom_range(0, 3) == 0);
            flush  = ($urandom_range(0, 6) == 0);
            edge_step();
            got = sample(); exp_v = sb.pop_front(); n_chk++;
            if (got !== exp_v) begin
                n_err++;
                $display("FAIL random%0d: got=%h exp=%h", i, got, exp_v);
            end
        end
        freeze = 1'b0;
        flush  = 1'b0;
    endtask

    task automatic test_reset_mid_freeze();
        rand_inputs();
        bus.in_valid = 1'b1;
        edge_step();
        got = sample(); exp_v = sb.pop_front(); n_chk++;
        if (got !== exp_v) begin
            n_err++;
            $display("FAIL pre_freeze_load: got=%h exp=%h", got, exp_v);
        end
        freeze = 1'b1;
        flush  = 1'b1;
        do_reset();
        got = sample(); n_chk++;
        if (got !== '0) begin
            n_err++;
            $display("FAIL reset_mid_freeze: got=%h exp=0", got);
        end
        flush = 1'b0;
        edge_step();
        got = sample(); exp_v = sb.pop_front(); n_chk++;
        if (got !== exp_v || got !== '0) begin
            n_err++;
            $display("FAIL after_reset_freeze: got=%h exp=%h", got, exp_v);
        end
        freeze = 1'b0;
    endtask

`ifdef ID_EX_PERF_EN
    task automatic test_perf();
        freeze = 1'b0;
        flush  = 1'b0;
        do_reset();
        flush = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        flush = 1'b0;
        n_chk++;
        if (flush_cnt_out !== 16'd3 || stall_cnt_out !== 16'd0) begin
            n_err++;
            $display("FAIL perf_flush: flush=%h stall=%h exp 3/0",
                     flush_cnt_out, stall_cnt_out);
        end
        freeze = 1'b1;
        repeat (65535) @(posedge clk);
        #1;
        n_chk++;
        if (stall_cnt_out !== 16'hFFFF) begin
            n_err++;
            $display("FAIL perf_stall_fill: got=%h exp=ffff", stall_cnt_out);
        end
        repeat (2) @(posedge clk);
        #1;
        freeze = 1'b0;
        n_chk++;
        if (stall_cnt_out !== 16'hFFFF || flush_cnt_out !== 16'd3) begin
            n_err++;
            $display("FAIL perf_saturate: stall=%h flush=%h exp ffff/3",
                     stall_cnt_out, flush_cnt_out);
        end
    endtask
`endif

    initial begin
        n_err  = 0;
        n_chk  = 0;
        mstate = '0;
        rst_n  = 1'b0;
        freeze = 1'b0;
        flush  = 1'b0;
        clear_inputs();
        @(posedge clk);
        #1;
        test_reset();
        test_load();
        test_freeze();
        test_flush_freeze();
        test_bubble();
        test_random();
        test_reset_mid_freeze();
`ifdef ID_EX_PERF_EN
        test_perf();
`endif
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
